// File: rtl/nand_cpu_pkg.sv
// Shared types for the rename/reclaim path: reclaim FSM states and the
// allocation log entry layout. Register counts default from NUM_D_REG / NUM_S_REG macros.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif

package nand_cpu_pkg;
   localparam int D_TAG_W = $clog2(`NUM_D_REG);
   localparam int S_TAG_W = $clog2(`NUM_S_REG);

   typedef enum logic {
      RC_IDLE = 1'b0,
      RC_WALK = 1'b1
   } reclaim_state_t;

   typedef struct packed {
      logic               use_rw;
      logic [D_TAG_W-1:0] rw_addr;
      logic               use_rs;
      logic [S_TAG_W-1:0] rs_addr;
   } rename_log_entry_t;

   function automatic logic [7:0] sat_inc_lo(input logic [7:0] v);
      return v;
   endfunction
endpackage

// File: rtl/rename_log.sv
// Circular allocation log: push at tail, retire at head, unwind at tail.
// Full/empty are told apart only by count; push and pop_tail never coincide.
module rename_log
   import nand_cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              push,
   input  rename_log_entry_t push_entry,
   input  logic              pop_head,
   input  logic              pop_tail,
   output rename_log_entry_t tail_entry,
   output logic [CW-1:0]     count
);
   rename_log_entry_t mem_q [DEPTH];
   rename_log_entry_t mem_d [DEPTH];
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     tail_m1;

   always_comb begin
      mem_d   = mem_q;
      tail_m1 = tail_q - PW'(1);
      if (push) mem_d[tail_q] = push_entry;
      head_d  = head_q + PW'(pop_head);
      tail_d  = tail_q + PW'(push) - PW'(pop_tail);
      count_d = count_q + CW'(push) - CW'(pop_head) - CW'(pop_tail);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign tail_entry = mem_q[tail_m1];
   assign count      = count_q;
endmodule

// File: rtl/reg_reclaim_ctrl.sv
// Returns speculatively renamed registers to the free list after a flush by
// unwinding the allocation log youngest-first. RECLAIM_STATS_EN adds flush/release counters.
module reg_reclaim_ctrl
   import nand_cpu_pkg::*;
#(
   parameter int NUM_D_REG = `NUM_D_REG,
   parameter int NUM_S_REG = `NUM_S_REG,
   parameter int DEPTH     = 16,
   localparam int DW = $clog2(NUM_D_REG),
   localparam int SW = $clog2(NUM_S_REG),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          alloc_valid,
   input  logic          alloc_use_rw,
   input  logic          alloc_use_rs,
   input  logic [DW-1:0] alloc_rw_addr,
   input  logic [SW-1:0] alloc_rs_addr,
   output logic          alloc_ready,
   input  logic          commit_valid,
   output logic          commit_ready,
   input  logic          flush_valid,
   input  logic [CW-1:0] flush_keep,
   output logic          rel_valid,
   output logic          rel_use_rw,
   output logic          rel_use_rs,
   output logic [DW-1:0] rel_rw_addr,
   output logic [SW-1:0] rel_rs_addr,
   output logic          busy,
`ifdef RECLAIM_STATS_EN
   output logic [15:0]   stat_flushes,
   output logic [15:0]   stat_released,
`endif
   output logic [CW-1:0] log_count
);
   reclaim_state_t    state_q, state_d;
   logic [CW-1:0]     target_q, target_d;
   logic              rel_valid_q, rel_valid_d;
   rename_log_entry_t rel_entry_q, rel_entry_d;
   rename_log_entry_t push_entry, tail_entry;
   logic              push, commit_fire, pop_tail, flush_start;
   logic [CW-1:0]     post_cnt, keep;

   assign push_entry = '{use_rw: alloc_use_rw, rw_addr: alloc_rw_addr,
                         use_rs: alloc_use_rs, rs_addr: alloc_rs_addr};

   rename_log #(.DEPTH(DEPTH)) u_log (
      .clk        (clk),
      .n_rst      (n_rst),
      .push       (push),
      .push_entry (push_entry),
      .pop_head   (commit_fire),
      .pop_tail   (pop_tail),
      .tail_entry (tail_entry),
      .count      (log_count)
   );

   // The first tail pop happens in the flush cycle itself so the youngest
   // entry is on rel_* the very next cycle; WALK then exits one cycle after
   // the last pop, keeping busy aligned with rel_valid.
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      rel_valid_d = 1'b0;
      rel_entry_d = '0;
      pop_tail    = 1'b0;
      flush_start = 1'b0;
      commit_fire = (state_q == RC_IDLE) && commit_valid && (log_count != '0);
      alloc_ready = (state_q == RC_IDLE) && !flush_valid && (log_count < CW'(DEPTH));
      push        = alloc_valid && alloc_ready;
      post_cnt    = log_count - CW'(commit_fire);
      keep        = (flush_keep < post_cnt) ? flush_keep : post_cnt;
      case (state_q)
         RC_IDLE: begin
            if (flush_valid && (keep != post_cnt)) begin
               state_d     = RC_WALK;
               target_d    = keep;
               pop_tail    = 1'b1;
               rel_valid_d = 1'b1;
               rel_entry_d = tail_entry;
               flush_start = 1'b1;
            end
         end
         RC_WALK: begin
            if (log_count > target_q) begin
               pop_tail    = 1'b1;
               rel_valid_d = 1'b1;
               rel_entry_d = tail_entry;
            end else begin
               state_d = RC_IDLE;
            end
         end
         default: state_d = RC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= RC_IDLE;
         target_q    <= '0;
         rel_valid_q <= 1'b0;
         rel_entry_q <= '0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         rel_valid_q <= rel_valid_d;
         rel_entry_q <= rel_entry_d;
      end
   end

   assign commit_ready = (state_q == RC_IDLE);
   assign busy         = (state_q == RC_WALK);
   assign rel_valid    = rel_valid_q;
   assign rel_use_rw   = rel_entry_q.use_rw;
   assign rel_rw_addr  = rel_entry_q.rw_addr;
   assign rel_use_rs   = rel_entry_q.use_rs;
   assign rel_rs_addr  = rel_entry_q.rs_addr;

`ifdef RECLAIM_STATS_EN
   logic [15:0] stat_flushes_q, stat_flushes_d;
   logic [15:0] stat_released_q, stat_released_d;

   always_comb begin
      stat_flushes_d  = stat_flushes_q;
      stat_released_d = stat_released_q;
      if (flush_start && (stat_flushes_q != 16'hFFFF))  stat_flushes_d  = stat_flushes_q + 16'd1;
      if (rel_valid_q && (stat_released_q != 16'hFFFF)) stat_released_d = stat_released_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         stat_flushes_q  <= '0;
         stat_released_q <= '0;
      end else begin
         stat_flushes_q  <= stat_flushes_d;
         stat_released_q <= stat_released_d;
      end
   end

   assign stat_flushes  = stat_flushes_q;
   assign stat_released = stat_released_q;
`endif
endmodule

// File: tb/tb_reg_reclaim_ctrl.sv
// Scoreboard bench for reg_reclaim_ctrl: a model log predicts every release
// at flush time; releases are popped and compared as the DUT emits them.
module tb_reg_reclaim_ctrl;
   import nand_cpu_pkg::*;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          alloc_valid, alloc_use_rw, alloc_use_rs;
   logic [4:0]    alloc_rw_addr;
   logic [2:0]    alloc_rs_addr;
   logic          alloc_ready, commit_valid, commit_ready, flush_valid;
   logic [CW-1:0] flush_keep;
   logic          rel_valid, rel_use_rw, rel_use_rs, busy;
   logic [4:0]    rel_rw_addr;
   logic [2:0]    rel_rs_addr;
   logic [CW-1:0] log_count;

   int checks = 0;
   int errors = 0;
   rename_log_entry_t mdl_log[$];
   rename_log_entry_t exp_rel[$];

   reg_reclaim_ctrl dut (
      .clk(clk), .n_rst(n_rst),
      .alloc_valid(alloc_valid), .alloc_use_rw(alloc_use_rw), .alloc_use_rs(alloc_use_rs),
      .alloc_rw_addr(alloc_rw_addr), .alloc_rs_addr(alloc_rs_addr), .alloc_ready(alloc_ready),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .flush_valid(flush_valid), .flush_keep(flush_keep),
      .rel_valid(rel_valid), .rel_use_rw(rel_use_rw), .rel_use_rs(rel_use_rs),
      .rel_rw_addr(rel_rw_addr), .rel_rs_addr(rel_rs_addr),
      .busy(busy), .log_count(log_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid = 0; alloc_use_rw = 0; alloc_use_rs = 0;
      alloc_rw_addr = '0; alloc_rs_addr = '0;
      commit_valid = 0; flush_valid = 0; flush_keep = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      n_rst = 0;
      tick();
      tick();
      n_rst = 1;
      mdl_log.delete();
      exp_rel.delete();
      #1;
   endtask

   task automatic do_alloc(input logic urw, input logic [4:0] rw, input logic urs, input logic [2:0] rs);
      rename_log_entry_t e;
      e.use_rw = urw; e.rw_addr = rw; e.use_rs = urs; e.rs_addr = rs;
      alloc_valid = 1; alloc_use_rw = urw; alloc_rw_addr = rw;
      alloc_use_rs = urs; alloc_rs_addr = rs;
      tick();
      alloc_valid = 0;
      if (mdl_log.size() < DEPTH) mdl_log.push_back(e);
   endtask

   task automatic do_commit();
      commit_valid = 1;
      tick();
      commit_valid = 0;
      if (mdl_log.size() > 0) void'(mdl_log.pop_front());
   endtask

   // Drives one flush (optionally with a same-cycle commit and a stray alloc)
   // and checks the release train cycle by cycle against the model.
   task automatic test_flush(input int keep, input bit with_commit, input string tag);
      int n, k;
      rename_log_entry_t e;
      if (with_commit && mdl_log.size() > 0) void'(mdl_log.pop_front());
      k = (keep < mdl_log.size()) ? keep : mdl_log.size();
      n = mdl_log.size() - k;
      repeat (n) exp_rel.push_back(mdl_log.pop_back());
      flush_valid = 1; flush_keep = CW'(keep); commit_valid = with_commit;
      alloc_valid = 1; alloc_use_rw = 1; alloc_rw_addr = 5'd31; alloc_use_rs = 1; alloc_rs_addr = 3'd7;
      #1;
      checks++;
      if (alloc_ready !== 1'b0) begin
         errors++; $display("FAIL %s_flush_alloc_ready: got %b exp 0", tag, alloc_ready);
      end
      tick();
      idle_inputs();
      for (int i = 0; i <= n; i++) begin
         #1;
         checks++;
         if (rel_valid !== (i < n) || busy !== (i < n) || alloc_ready !== (i >= n)) begin
            errors++;
            $display("FAIL %s_timing cyc%0d: rel_valid/busy/alloc_ready got %b%b%b exp %b%b%b",
                     tag, i, rel_valid, busy, alloc_ready, i < n, i < n, i >= n);
         end
         if (rel_valid === 1'b1) begin
            checks++;
            if (exp_rel.size() == 0) begin
               errors++; $display("FAIL %s_extra_release cyc%0d: rw %0d rs %0d exp none", tag, i, rel_rw_addr, rel_rs_addr);
            end else begin
               e = exp_rel.pop_front();
               if (rel_use_rw !== e.use_rw || rel_rw_addr !== e.rw_addr ||
                   rel_use_rs !== e.use_rs || rel_rs_addr !== e.rs_addr) begin
                  errors++;
                  $display("FAIL %s_release cyc%0d: got rw %b/%0d rs %b/%0d exp rw %b/%0d rs %b/%0d",
                           tag, i, rel_use_rw, rel_rw_addr, rel_use_rs, rel_rs_addr,
                           e.use_rw, e.rw_addr, e.use_rs, e.rs_addr);
               end
            end
         end
         if (i < n) tick();
      end
      checks++;
      if (exp_rel.size() != 0 || log_count !== CW'(mdl_log.size())) begin
         errors++;
         $display("FAIL %s_after: pending %0d log_count %0d exp pending 0 log_count %0d",
                  tag, exp_rel.size(), log_count, mdl_log.size());
         exp_rel.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (log_count !== '0 || rel_valid !== 0 || busy !== 0 || alloc_ready !== 1 || commit_ready !== 1 ||
          rel_use_rw !== 0 || rel_use_rs !== 0 || rel_rw_addr !== '0 || rel_rs_addr !== '0) begin
         errors++;
         $display("FAIL reset: cnt %0d rv %b busy %b ar %b cr %b exp 0 0 0 1 1", log_count, rel_valid, busy, alloc_ready, commit_ready);
      end
   endtask

   task automatic test_alloc();
      do_alloc(1, 5'd5, 0, 3'd0);
      do_alloc(1, 5'd6, 1, 3'd2);
      do_alloc(1, 5'd7, 0, 3'd0);
      #1;
      checks++;
      if (log_count !== 5'd3 || alloc_ready !== 1 || rel_valid !== 0) begin
         errors++; $display("FAIL alloc3: cnt %0d ar %b rv %b exp 3 1 0", log_count, alloc_ready, rel_valid);
      end
   endtask

   task automatic test_flush_basic();
      test_flush(1, 0, "basic");
      checks++;
      if (log_count !== 5'd1) begin
         errors++; $display("FAIL basic_count: got %0d exp 1", log_count);
      end
   endtask

   task automatic test_fill();
      do_reset();
      do_commit();
      checks++;
      if (log_count !== '0) begin
         errors++; $display("FAIL empty_commit: cnt %0d exp 0", log_count);
      end
      for (int i = 0; i < DEPTH; i++) do_alloc(i[0], 5'(i + 8), ~i[0], 3'(i));
      #1;
      checks++;
      if (log_count !== 5'd16 || alloc_ready !== 0) begin
         errors++; $display("FAIL full: cnt %0d ar %b exp 16 0", log_count, alloc_ready);
      end
      do_alloc(1, 5'd1, 1, 3'd1);
      checks++;
      if (log_count !== 5'd16) begin
         errors++; $display("FAIL overflow_drop: cnt %0d exp 16", log_count);
      end
      do_commit();
      #1;
      checks++;
      if (log_count !== 5'd15 || alloc_ready !== 1) begin
         errors++; $display("FAIL commit_after_full: cnt %0d ar %b exp 15 1", log_count, alloc_ready);
      end
      commit_valid = 1;
      do_alloc(1, 5'd3, 0, 3'd4);
      commit_valid = 0;
      void'(mdl_log.pop_front());
      checks++;
      if (log_count !== 5'd15) begin
         errors++; $display("FAIL commit_and_alloc: cnt %0d exp 15", log_count);
      end
      // Unwind the whole wrapped log to check the pointers survived wrap.
      test_flush(0, 0, "wrap");
   endtask

   task automatic test_commit_flush();
      do_reset();
      do_alloc(1, 5'd10, 0, 3'd0);
      do_alloc(0, 5'd11, 1, 3'd3);
      do_alloc(0, 5'd12, 0, 3'd5);
      test_flush(0, 1, "commit_flush");
      checks++;
      if (log_count !== '0) begin
         errors++; $display("FAIL commit_flush_count: got %0d exp 0", log_count);
      end
   endtask

   task automatic test_keep_clamp();
      do_reset();
      for (int i = 0; i < 4; i++) do_alloc(1, 5'(20 + i), 1, 3'(i));
      test_flush(9, 0, "clamp");
      checks++;
      if (log_count !== 5'd4) begin
         errors++; $display("FAIL clamp_count: got %0d exp 4", log_count);
      end
   endtask

   task automatic test_reset_walk();
      do_reset();
      for (int i = 0; i < 4; i++) do_alloc(1, 5'(i + 1), 0, 3'd0);
      flush_valid = 1; flush_keep = '0;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (busy !== 1 || rel_valid !== 1 || rel_rw_addr !== 5'd3) begin
         errors++; $display("FAIL walk_2nd: busy %b rv %b rw %0d exp 1 1 3", busy, rel_valid, rel_rw_addr);
      end
      n_rst = 0;
      tick();
      n_rst = 1;
      mdl_log.delete();
      #1;
      checks++;
      if (rel_valid !== 0 || busy !== 0 || log_count !== '0 || alloc_ready !== 1) begin
         errors++;
         $display("FAIL reset_walk: rv %b busy %b cnt %0d ar %b exp 0 0 0 1", rel_valid, busy, log_count, alloc_ready);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int it = 0; it < 8; it++) begin
         int na;
         na = $urandom_range(1, 12);
         for (int j = 0; j < na; j++)
            do_alloc(1'($urandom), 5'($urandom), 1'($urandom), 3'($urandom));
         test_flush($urandom_range(0, 10), 1'($urandom), "rand");
      end
   endtask

   initial begin
      n_rst = 0;
      idle_inputs();
      test_reset();
      test_alloc();
      test_flush_basic();
      test_fill();
      test_commit_flush();
      test_keep_clamp();
      test_reset_walk();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
